delta_sigma_mod: RTL and testbench
==================================

Name: delta_sigma_mod

Overview:
- Digital delta-sigma modulator: converts a WIDTH-bit unsigned sample into a 1-bit pulse-density stream.
- Mean density of `pwm` equals vin/2^WIDTH.
- Sits between the sample source (new word each clock) and an external RC/analog reconstruction filter.
- Noise-shaping order is selectable: 1 or 2.

Parameters:
- WIDTH, 20, input sample width in bits.
- ORDER, 2, modulator order; legal values 1 or 2. Any other value is an elaboration error.

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high; clears all state
- vin  input  WIDTH  unsigned input sample; full scale is 2^WIDTH-1
- pwm  output  1  registered pulse-density output

Behaviour:
- Reset values: `vin_q`, all accumulators/integrators and `pwm` are 0. Reset is sampled on the rising edge and overrides all updates; asserting it mid-stream clears state on that edge.
- Input stage: `vin_q <= vin` every cycle. `vin` may change every cycle; there is no handshake or valid signal.
- ORDER=1 (accumulator modulator):
  - `acc` is WIDTH bits, unsigned.
  - {carry, sum} = acc + vin_q (WIDTH+1 bits); acc <= sum; pwm <= carry.
  - Wrap-around of `acc` is intended.
  - Over any 2^WIDTH consecutive cycles, the count of ones equals the constant vin exactly.
- ORDER=2 (CIFB, two integrators):
  - x = signed(vin_q) - 2^(WIDTH-1).
  - fb = pwm ? +2^(WIDTH-1) : -2^(WIDTH-1), using the current registered `pwm`.
  - i1n = int1 + x - fb; i2n = int2 + i1n - fb.
  - int1 is WIDTH+3 bits signed; int2 is WIDTH+5 bits signed.
  - Saturation: i1n clamps to ±2^(WIDTH+1); i2n clamps to ±2^(WIDTH+3). No two's-complement wrap is permitted.
  - int1 <= sat(i1n); int2 <= sat(i2n); pwm <= (sat(i2n) >= 0).
- Latency: a `vin` change first affects `pwm` 2 rising edges later (input register, then state/output register).
- Extremes:
  - vin=0 yields pwm constantly 0 (ORDER=1); density ≤1/4096 (ORDER=2).
  - vin=2^WIDTH-1 yields density ≥ 1-2^-12.
- `pwm` is a flop output; there is no combinational path from `vin`.

Optional Feature:
- Macro DSM_DITHER_EN.
- Defined:
  - Adds a 16-bit Fibonacci LFSR, taps 16,14,13,11, reset seed 16'hACE1, advancing every non-reset cycle.
  - The modulator input becomes x + (lfsr[0] ? +1 : -1) in ORDER=2, or vin_q + lfsr[0] with the sum saturated at 2^WIDTH-1 in ORDER=1.
  - Purpose: breaks idle tones.
  - Long-run density error stays ≤ 2^-(WIDTH-1).
- Undefined: no LFSR logic; behaviour exactly as specified above. Bit-exact tests assume it is undefined.

Decomposition:
- Package dsm_pkg holds:
  - localparams for default WIDTH;
  - integrator widths (WIDTH+3, WIDTH+5) and saturation limits;
  - LFSR seed and tap constants;
  - a function for signed saturation.
- One sub-module, dsm_sat_integrator: a parameterised width/limit accumulator with clamp, instantiated twice in ORDER=2.
- ORDER=1 is inline logic.

Test Plan:
- Reset then vin=0, ORDER=1 -> pwm=0 for 1000 cycles; during reset, pwm=0 and all state is 0.
- ORDER=1, vin=20'h80000 -> after 2-cycle latency, pwm alternates 1,0,1,0...; ones in 1024 cycles = 512.
- ORDER=1, vin=20'h40000 held 2^20 cycles -> exactly 262144 ones; the pattern repeats with period 4 (one 1 per 4).
- ORDER=2, vin=20'h80000 -> ones in 4096 cycles within 2048±2; int1/int2 never reach saturation limits.
- ORDER=2, vin=20'hFFFFF then 20'h00000 -> no integrator wrap (checked against bounds); density ≥4090/4096 ones, then ≤6/4096 after settling 64 cycles.
- Mid-stream reset: vin=20'hC0000 for 100 cycles, assert reset 1 cycle -> next cycle pwm=0 and all integrators 0; the post-reset sequence is identical to a fresh start.

Source files
------------

// File: rtl/dsm_pkg.sv
// Shared constants and helpers for the delta-sigma modulator.
//
// Contents:
//   DefWidth          default sample width
//   Int1WidthOfs/...  integrator widths and clamp exponents, relative to WIDTH
//   LfsrSeed/LfsrTaps dither LFSR constants (used only when DSM_DITHER_EN is defined)
//   sat_signed()      symmetric signed clamp to +/-2^lim_exp
package dsm_pkg;

  localparam int unsigned DefWidth = 20;

  // int1 is WIDTH+3 bits and clamps at +/-2^(WIDTH+1).
  // int2 is WIDTH+5 bits and clamps at +/-2^(WIDTH+3).
  localparam int unsigned Int1WidthOfs = 3;
  localparam int unsigned Int2WidthOfs = 5;
  localparam int unsigned Int1LimOfs   = 1;
  localparam int unsigned Int2LimOfs   = 3;

  // Fibonacci LFSR, taps 16,14,13,11: shifts right, feedback from bits 0,2,3,5.
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'h002D;

  // Works on 64-bit values, so integrator widths must stay below 63 bits.
  function automatic longint sat_signed(input longint v, input int unsigned lim_exp);
    longint lim;
    longint res;
    lim = 64'sd1 <<< lim_exp;
    if (v > lim) begin
      res = lim;
    end else if (v < -lim) begin
      res = -lim;
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/dsm_sat_integrator.sv
// Saturating signed integrator: acc <= clamp(acc + in, +/-2^LimExp).
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high clear of the accumulator
//   i_in   signed increment, InW bits (InW <= AccW+2)
//   o_sat  clamped next value (combinational), used by downstream stages
//   o_acc  registered accumulator value
module dsm_sat_integrator
  import dsm_pkg::*;
#(
  parameter int unsigned AccW   = 23,
  parameter int unsigned InW    = 22,
  parameter int unsigned LimExp = 21
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic signed [InW-1:0]  i_in,
  output logic signed [AccW-1:0] o_sat,
  output logic signed [AccW-1:0] o_acc
);

  // Two guard bits so the raw sum can never wrap before it is clamped.
  localparam int unsigned SumW = AccW + 2;

  logic signed [AccW-1:0] r_acc;
  logic signed [SumW-1:0] w_sum;

  always_comb begin
    w_sum = SumW'(r_acc) + SumW'(i_in);
    o_sat = AccW'(sat_signed(longint'(w_sum), LimExp));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc <= '0;
    end else begin
      r_acc <= o_sat;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/delta_sigma_mod.sv
// Digital delta-sigma modulator: WIDTH-bit unsigned sample to 1-bit pulse-density stream.
// Mean density of pwm is vin/2^WIDTH. ORDER selects first-order accumulator (1) or
// second-order CIFB loop with saturating integrators (2).
//
// Ports:
//   clock  rising-edge system clock
//   reset  synchronous active-high, clears all state
//   vin    unsigned input sample, may change every cycle
//   pwm    registered pulse-density output (2-cycle latency from vin)
//
// Optional feature: define DSM_DITHER_EN to add a 16-bit LFSR that dithers the
// modulator input by +/-1 LSB (ORDER=2) or +0/+1 LSB saturating (ORDER=1).
module delta_sigma_mod
  import dsm_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned ORDER = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] vin,
  output logic             pwm
);

  logic [WIDTH-1:0] r_vin;
  logic             r_pwm;
  logic             w_pwm_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vin <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_vin <= vin;
      r_pwm <= w_pwm_d;
    end
  end

  assign pwm = r_pwm;

`ifdef DSM_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_dither;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr <= LfsrSeed;
    end else begin
      r_lfsr <= {^(r_lfsr & LfsrTaps), r_lfsr[15:1]};
    end
  end

  assign w_dither = r_lfsr[0];
`endif

  if (ORDER == 1) begin : g_order1
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_in;
    logic [WIDTH:0]   w_sum;
`ifdef DSM_DITHER_EN
    logic [WIDTH:0]   w_in_ext;
`endif

    always_comb begin
`ifdef DSM_DITHER_EN
      w_in_ext = {1'b0, r_vin} + {{WIDTH{1'b0}}, w_dither};
      // Clamp at full scale rather than wrapping to zero.
      w_in     = w_in_ext[WIDTH] ? '1 : w_in_ext[WIDTH-1:0];
`else
      w_in     = r_vin;
`endif
      // Carry out of the wrapping accumulator is the output bit.
      w_sum    = {1'b0, r_acc} + {1'b0, w_in};
      w_pwm_d  = w_sum[WIDTH];
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        r_acc <= '0;
      end else begin
        r_acc <= w_sum[WIDTH-1:0];
      end
    end
  end else if (ORDER == 2) begin : g_order2
    localparam int unsigned Int1W = WIDTH + Int1WidthOfs;
    localparam int unsigned Int2W = WIDTH + Int2WidthOfs;
    // x - fb (+dither) spans about +/-2^WIDTH; sat(i1n) - fb stays inside Int1W+1 bits.
    localparam int unsigned In1W  = WIDTH + 2;
    localparam int unsigned In2W  = Int1W + 1;
    localparam logic signed [In1W-1:0] Half = In1W'(64'd1 << (WIDTH - 1));

    logic signed [In1W-1:0]  w_x;
    logic signed [In1W-1:0]  w_fb;
    logic signed [In1W-1:0]  w_term1;
    logic signed [In2W-1:0]  w_term2;
    logic signed [Int1W-1:0] w_i1_sat;
    logic signed [Int1W-1:0] w_i1_acc;
    logic signed [Int2W-1:0] w_i2_sat;
    logic signed [Int2W-1:0] w_i2_acc;

    always_comb begin
      // Re-centre the unsigned sample around zero.
      w_x     = $signed({2'b00, r_vin}) - Half;
      w_fb    = r_pwm ? Half : -Half;
`ifdef DSM_DITHER_EN
      w_term1 = w_x + (w_dither ? In1W'(1) : '1) - w_fb;
`else
      w_term1 = w_x - w_fb;
`endif
      w_term2 = In2W'(w_i1_sat) - In2W'(w_fb);
      w_pwm_d = ~w_i2_sat[Int2W-1];
    end

    dsm_sat_integrator #(
      .AccW   (Int1W),
      .InW    (In1W),
      .LimExp (WIDTH + Int1LimOfs)
    ) u_int1 (
      .clock (clock),
      .reset (reset),
      .i_in  (w_term1),
      .o_sat (w_i1_sat),
      .o_acc (w_i1_acc)
    );

    dsm_sat_integrator #(
      .AccW   (Int2W),
      .InW    (In2W),
      .LimExp (WIDTH + Int2LimOfs)
    ) u_int2 (
      .clock (clock),
      .reset (reset),
      .i_in  (w_term2),
      .o_sat (w_i2_sat),
      .o_acc (w_i2_acc)
    );
  end else begin : g_bad_order
    $error("delta_sigma_mod: ORDER must be 1 or 2");
  end

endmodule

// File: tb/tb_delta_sigma_mod.sv
module tb_delta_sigma_mod;

  localparam longint H   = 64'sd1 << 19;
  localparam longint L1  = 64'sd1 << 21;
  localparam longint L2  = 64'sd1 << 23;

  logic        clock;
  logic        reset;
  logic [19:0] vin20;
  logic [7:0]  vin8;
  logic        pwm1;
  logic        pwm2;
  logic        pwm8;

  delta_sigma_mod #(.WIDTH(20), .ORDER(1)) u_d1 (
    .clock (clock), .reset (reset), .vin (vin20), .pwm (pwm1)
  );
  delta_sigma_mod #(.WIDTH(20), .ORDER(2)) u_d2 (
    .clock (clock), .reset (reset), .vin (vin20), .pwm (pwm2)
  );
  delta_sigma_mod #(.WIDTH(8), .ORDER(1)) u_d8 (
    .clock (clock), .reset (reset), .vin (vin8), .pwm (pwm8)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    string       name;
    int          tgt;
    bit          rst;
    logic [19:0] vin;
    int          settle;
    int          ncyc;
    int          lo;
    int          hi;
    bit          no_sat;
  } row_t;

  row_t rows[8];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  longint m1_acc, m1_vq, m8_acc, m8_vq, m2_int1, m2_int2, m2_vq;
  logic   m1_pwm, m2_pwm, m8_pwm;
  logic   q1[$];
  logic   q2[$];
  logic   q8[$];

  int     mm1, mm2, mm8;
  int     ones;
  int     cnt_tgt;
  bit     counting;
  longint pk1, pk2;

  logic [63:0] seq_a1, seq_a2, seq_b1, seq_b2;

  function automatic longint msat(input longint v, input longint lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic check_range(input string name, input longint got, input longint lo,
                             input longint hi);
    n_tests++;
    if (got < lo || got > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic model_step();
    longint s, x, fb, i1, i2;
    if (reset) begin
      m1_acc = 0; m1_vq = 0; m1_pwm = 1'b0;
      m8_acc = 0; m8_vq = 0; m8_pwm = 1'b0;
      m2_int1 = 0; m2_int2 = 0; m2_vq = 0; m2_pwm = 1'b0;
    end else begin
      s      = m1_acc + m1_vq;
      m1_pwm = (s >= (64'sd1 << 20));
      m1_acc = m1_pwm ? s - (64'sd1 << 20) : s;
      m1_vq  = longint'(vin20);

      s      = m8_acc + m8_vq;
      m8_pwm = (s >= 256);
      m8_acc = m8_pwm ? s - 256 : s;
      m8_vq  = longint'(vin8);

      x       = m2_vq - H;
      fb      = m2_pwm ? H : -H;
      i1      = msat(m2_int1 + x - fb, L1);
      i2      = msat(m2_int2 + i1 - fb, L2);
      m2_int1 = i1;
      m2_int2 = i2;
      m2_pwm  = (i2 >= 0);
      m2_vq   = longint'(vin20);
    end
    q1.push_back(m1_pwm);
    q2.push_back(m2_pwm);
    q8.push_back(m8_pwm);
  endtask

  task automatic tick();
    longint p;
    @(posedge clock);
    model_step();
    #1;
    if (q1.pop_front() !== pwm1) mm1++;
    if (q2.pop_front() !== pwm2) mm2++;
    if (q8.pop_front() !== pwm8) mm8++;
    if (counting) begin
      case (cnt_tgt)
        1: ones += (pwm1 === 1'b1) ? 1 : 0;
        2: ones += (pwm2 === 1'b1) ? 1 : 0;
        default: ones += (pwm8 === 1'b1) ? 1 : 0;
      endcase
    end
    p = u_d2.g_order2.u_int1.r_acc;
    if (p < 0) p = -p;
    if (p > pk1) pk1 = p;
    p = u_d2.g_order2.u_int2.r_acc;
    if (p < 0) p = -p;
    if (p > pk2) pk2 = p;
  endtask

  task automatic check_state_zero(input string tag);
    check_range({tag, "/pwm1"}, longint'(pwm1), 0, 0);
    check_range({tag, "/pwm2"}, longint'(pwm2), 0, 0);
    check_range({tag, "/pwm8"}, longint'(pwm8), 0, 0);
    check_range({tag, "/acc1"}, longint'(u_d1.g_order1.r_acc), 0, 0);
    check_range({tag, "/vinq1"}, longint'(u_d1.r_vin), 0, 0);
    check_range({tag, "/vinq2"}, longint'(u_d2.r_vin), 0, 0);
    check_range({tag, "/int1"}, longint'(u_d2.g_order2.u_int1.r_acc), 0, 0);
    check_range({tag, "/int2"}, longint'(u_d2.g_order2.u_int2.r_acc), 0, 0);
  endtask

  initial begin
    rows[0] = '{"o1_zero",    1, 1'b1, 20'h00000, 1,  1000, 0,    0,    1'b0};
    rows[1] = '{"o1_half",    1, 1'b0, 20'h80000, 1,  1024, 512,  512,  1'b0};
    rows[2] = '{"o1_quarter", 1, 1'b0, 20'h40000, 1,  1024, 256,  256,  1'b0};
    rows[3] = '{"o1_full",    1, 1'b0, 20'hFFFFF, 1,  4096, 4095, 4096, 1'b0};
    rows[4] = '{"w8_exact77", 8, 1'b1, 20'h0004D, 1,  256,  77,   77,   1'b0};
    rows[5] = '{"o2_half",    2, 1'b1, 20'h80000, 64, 4096, 2046, 2050, 1'b1};
    rows[6] = '{"o2_full",    2, 1'b0, 20'hFFFFF, 64, 4096, 4090, 4096, 1'b0};
    rows[7] = '{"o2_zero",    2, 1'b0, 20'h00000, 64, 4096, 0,    6,    1'b0};

    reset = 1'b1; vin20 = '0; vin8 = '0;
    counting = 1'b0; cnt_tgt = 1; ones = 0;
    mm1 = 0; mm2 = 0; mm8 = 0; pk1 = 0; pk2 = 0;

    repeat (3) tick();
    check_state_zero("reset");
    reset = 1'b0;

    for (int r = 0; r < 8; r++) begin
      mm1 = 0; mm2 = 0; mm8 = 0; pk1 = 0; pk2 = 0; ones = 0;
      cnt_tgt = rows[r].tgt;
      vin20 = rows[r].vin;
      vin8  = rows[r].vin[7:0];
      if (rows[r].rst) begin
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
      end
      repeat (rows[r].settle) tick();
      counting = 1'b1;
      repeat (rows[r].ncyc) tick();
      counting = 1'b0;
      check_range({rows[r].name, "/ones"}, ones, rows[r].lo, rows[r].hi);
      check_range({rows[r].name, "/exact_d1"}, mm1, 0, 0);
      check_range({rows[r].name, "/exact_d2"}, mm2, 0, 0);
      check_range({rows[r].name, "/exact_d8"}, mm8, 0, 0);
      if (rows[r].tgt == 2) begin
        if (rows[r].no_sat) begin
          check_range({rows[r].name, "/int1_peak"}, pk1, 0, L1 - 1);
          check_range({rows[r].name, "/int2_peak"}, pk2, 0, L2 - 1);
        end else begin
          check_range({rows[r].name, "/int1_peak"}, pk1, 0, L1);
          check_range({rows[r].name, "/int2_peak"}, pk2, 0, L2);
        end
      end
    end

    // Mid-stream one-cycle reset must behave exactly like a fresh start.
    mm1 = 0; mm2 = 0; mm8 = 0;
    vin20 = 20'hC0000; vin8 = 8'hC0;
    repeat (100) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_state_zero("midreset");
    for (int i = 0; i < 64; i++) begin
      tick();
      seq_a1[i] = pwm1;
      seq_a2[i] = pwm2;
    end
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      seq_b1[i] = pwm1;
      seq_b2[i] = pwm2;
    end
    n_tests++;
    if (seq_a1 !== seq_b1) begin
      n_fail++;
      $display("FAIL midreset/seq_d1: got %h, required %h", seq_a1, seq_b1);
    end
    n_tests++;
    if (seq_a2 !== seq_b2) begin
      n_fail++;
      $display("FAIL midreset/seq_d2: got %h, required %h", seq_a2, seq_b2);
    end
    check_range("midreset/exact_d1", mm1, 0, 0);
    check_range("midreset/exact_d2", mm2, 0, 0);
    check_range("midreset/exact_d8", mm8, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
